// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: single-stage registered bitwise logic unit with valid/ready
// handshake on both sides and a wrapping count of accepted operations.
// Optional feature macro: LOGIC_UNIT_REDUCE_EN adds registered AND/OR/XOR
// reductions of the result (red_and, red_or, red_xor).
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [CNT_W-1:0] op_count
`ifdef LOGIC_UNIT_REDUCE_EN
  ,
  output logic             red_and,
  output logic             red_or,
  output logic             red_xor
`endif
);

  // Bitwise operation selected by opcode; every code is a legal operation.
  function automatic logic [WIDTH-1:0] logic_fn(
    input logic [2:0]       op_f,
    input logic [WIDTH-1:0] a_f,
    input logic [WIDTH-1:0] b_f
  );
    logic [WIDTH-1:0] r;
    case (op_f)
      3'd0:    r = ~a_f;
      3'd1:    r = a_f & b_f;
      3'd2:    r = ~(a_f & b_f);
      3'd3:    r = a_f | b_f;
      3'd4:    r = ~(a_f | b_f);
      3'd5:    r = a_f ^ b_f;
      3'd6:    r = ~(a_f ^ b_f);
      3'd7:    r = a_f;
      default: r = a_f;
    endcase
    return r;
  endfunction

  logic             accept;
  logic [WIDTH-1:0] next_result;

  // The stage can take a new operand whenever it is empty or being drained.
  assign in_ready = !out_valid || out_ready;

  // Accept decision and the result that would be captured on this edge.
  always_comb begin
    accept      = in_valid && in_ready;
    next_result = logic_fn(op, a, b);
  end

  // Output stage: capture on accept, drop valid on a drain without refill,
  // hold everything while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= {WIDTH{1'b0}};
      zero      <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      result    <= next_result;
      zero      <= (next_result == {WIDTH{1'b0}});
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

  // Accepted-operation counter; wraps silently and ignores output transfers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_count <= {CNT_W{1'b0}};
    end else if (accept) begin
      op_count <= op_count + CNT_W'(1'b1);
    end else begin
      op_count <= op_count;
    end
  end

`ifdef LOGIC_UNIT_REDUCE_EN
  // Reductions are taken from the freshly computed result so they stay aligned
  // with result and hold under the same conditions.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      red_and <= 1'b0;
      red_or  <= 1'b0;
      red_xor <= 1'b0;
    end else if (accept) begin
      red_and <= &next_result;
      red_or  <= |next_result;
      red_xor <= ^next_result;
    end else begin
      red_and <= red_and;
      red_or  <= red_or;
      red_xor <= red_xor;
    end
  end
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe. Two instances share all inputs:
// the default build (CNT_W=16) and a narrow-counter build (CNT_W=4) used to
// observe counter wrap. A transaction-level model tracks expected outputs.
module tb_logic_unit_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [2:0]  op;

  logic        in_ready, out_valid, zero;
  logic [7:0]  result;
  logic [15:0] op_count;
  logic        in_ready4, out_valid4, zero4;
  logic [7:0]  result4;
  logic [3:0]  op_count4;
`ifdef LOGIC_UNIT_REDUCE_EN
  logic        red_and, red_or, red_xor;
  logic        red_and4, red_or4, red_xor4;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic        m_valid  = 1'b0;
  logic [7:0]  m_result = 8'h00;
  logic        m_zero   = 1'b0;
  logic [31:0] m_count  = 32'd0;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .op_count(op_count)
`ifdef LOGIC_UNIT_REDUCE_EN
    , .red_and(red_and), .red_or(red_or), .red_xor(red_xor)
`endif
  );

  logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .a(a), .b(b), .op(op), .out_valid(out_valid4), .out_ready(out_ready),
    .result(result4), .zero(zero4), .op_count(op_count4)
`ifdef LOGIC_UNIT_REDUCE_EN
    , .red_and(red_and4), .red_or(red_or4), .red_xor(red_xor4)
`endif
  );

  // Opcode table written directly from the operation list.
  function automatic logic [7:0] ref_f(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    case (o)
      3'd0: return ~x;
      3'd1: return x & y;
      3'd2: return ~(x & y);
      3'd3: return x | y;
      3'd4: return ~(x | y);
      3'd5: return x ^ y;
      3'd6: return ~(x ^ y);
      default: return x;
    endcase
  endfunction

  // Advance one clock; update the model from the inputs seen at the edge.
  task automatic cycle();
    logic rdy, acc;
    @(posedge clk);
    rdy = !m_valid || out_ready;
    acc = in_valid && rdy;
    if (!rst_n) begin
      m_valid = 1'b0; m_result = 8'h00; m_zero = 1'b0; m_count = 32'd0;
    end else if (acc) begin
      m_result = ref_f(op, a, b);
      m_zero   = (m_result == 8'h00);
      m_valid  = 1'b1;
      m_count  = m_count + 32'd1;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    a = 8'h00; b = 8'h00; op = 3'd0;
    do_reset();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_tests++; if (result !== 8'h00) begin n_fail++; $display("FAIL reset_result got %h want 00", result); end
    n_tests++; if (zero !== 1'b0) begin n_fail++; $display("FAIL reset_zero got %b want 0", zero); end
    n_tests++; if (op_count !== 16'd0 || op_count4 !== 4'd0) begin n_fail++; $display("FAIL reset_op_count got %0d/%0d want 0", op_count, op_count4); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_all_ops();
    logic [7:0] want [8];
    want = '{8'h5A, 8'h05, 8'hFA, 8'hAF, 8'h50, 8'hAA, 8'h55, 8'hA5};
    do_reset();
    a = 8'hA5; b = 8'h0F; out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      op = 3'(i);
      cycle();
      n_tests++;
      if (result !== want[i] || out_valid !== 1'b1 || result !== m_result) begin
        n_fail++; $display("FAIL all_ops op=%0d got %h valid=%b want %h", i, result, out_valid, want[i]);
      end
    end
    in_valid = 1'b0;
    cycle();
    n_tests++; if (op_count !== 16'd8) begin n_fail++; $display("FAIL all_ops_count got %0d want 8", op_count); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL all_ops_drain got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [15:0] cnt0;
    do_reset();
    in_valid = 1'b1; op = 3'd1; a = 8'hFF; b = 8'h3C; out_ready = 1'b1;
    cycle();
    cnt0 = op_count;
    n_tests++; if (result !== 8'h3C || cnt0 !== 16'd1) begin n_fail++; $display("FAIL bp_first got %h cnt %0d want 3C cnt 1", result, cnt0); end
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
      #1;
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
      cycle();
      n_tests++;
      if (result !== 8'h3C || op_count !== 16'd1 || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold got %h cnt %0d valid %b want 3C cnt 1 valid 1", result, op_count, out_valid);
      end
    end
    out_ready = 1'b1; a = 8'h12; b = 8'h34; op = 3'd3;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
    cycle();
    n_tests++;
    if (result !== 8'h36 || op_count !== 16'd2 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_release got %h cnt %0d want 36 cnt 2", result, op_count);
    end
    in_valid = 1'b0;
    cycle();
  endtask

  task automatic test_zero();
    in_valid = 1'b1; out_ready = 1'b1;
    op = 3'd5; a = 8'h77; b = 8'h77;
    cycle();
    n_tests++; if (result !== 8'h00 || zero !== 1'b1) begin n_fail++; $display("FAIL zero_xor got %h z=%b want 00 z=1", result, zero); end
    op = 3'd3; a = 8'h00; b = 8'h01;
    cycle();
    n_tests++; if (result !== 8'h01 || zero !== 1'b0) begin n_fail++; $display("FAIL zero_or got %h z=%b want 01 z=0", result, zero); end
    in_valid = 1'b0;
    cycle();
  endtask

  task automatic test_wrap();
    int guard;
    do_reset();
    guard = 0;
    while (m_count < 32'd17 && guard < 2000) begin
      in_valid = 1'($urandom); out_ready = 1'($urandom);
      a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
      cycle();
      guard++;
    end
    in_valid = 1'b0;
    n_tests++; if (guard >= 2000) begin n_fail++; $display("FAIL wrap_timeout got %0d accepts want 17", m_count); end
    out_ready = 1'b0;
    cycle();
    cycle();
    n_tests++; if (op_count4 !== 4'd1) begin n_fail++; $display("FAIL wrap_cnt4 got %0d want 1", op_count4); end
    n_tests++; if (op_count !== 16'd17) begin n_fail++; $display("FAIL wrap_cnt16 got %0d want 17", op_count); end
    out_ready = 1'b1;
    cycle();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'($urandom); out_ready = ($urandom_range(3) != 0);
      a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
      cycle();
      n_tests++;
      if (out_valid !== m_valid || (m_valid && (result !== m_result || zero !== m_zero))
          || op_count !== m_count[15:0] || op_count4 !== m_count[3:0]) begin
        n_fail++;
        $display("FAIL random[%0d] got v=%b r=%h z=%b c=%0d want v=%b r=%h z=%b c=%0d",
                 i, out_valid, result, zero, op_count, m_valid, m_result, m_zero, m_count[15:0]);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    cycle();
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; out_ready = 1'b0; op = 3'd7; a = 8'hC3; b = 8'h00;
    cycle();
    in_valid = 1'b0;
    cycle();
    n_tests++; if (out_valid !== 1'b1 || result !== 8'hC3) begin n_fail++; $display("FAIL mid_setup got v=%b r=%h want 1 C3", out_valid, result); end
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    n_tests++;
    if (out_valid !== 1'b0 || result !== 8'h00 || op_count !== 16'd0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset got v=%b r=%h c=%0d rdy=%b want 0 00 0 1", out_valid, result, op_count, in_ready);
    end
    in_valid = 1'b1; op = 3'd0; a = 8'h0F;
    cycle();
    in_valid = 1'b0;
    n_tests++; if (out_valid !== 1'b1 || result !== 8'hF0 || op_count !== 16'd1) begin n_fail++; $display("FAIL mid_first_accept got v=%b r=%h c=%0d want 1 F0 1", out_valid, result, op_count); end
    out_ready = 1'b1;
    cycle();
  endtask

`ifdef LOGIC_UNIT_REDUCE_EN
  task automatic test_reduce();
    in_valid = 1'b1; out_ready = 1'b1;
    op = 3'd2; a = 8'hF0; b = 8'hF0;
    cycle();
    n_tests++;
    if (result !== 8'h0F || red_and !== 1'b0 || red_or !== 1'b1 || red_xor !== 1'b0) begin
      n_fail++; $display("FAIL reduce_nand got %h and=%b or=%b xor=%b want 0F 0 1 0", result, red_and, red_or, red_xor);
    end
    op = 3'd7; a = 8'hFF; b = 8'($urandom);
    cycle();
    n_tests++;
    if (result !== 8'hFF || red_and !== 1'b1 || red_xor !== 1'b0) begin
      n_fail++; $display("FAIL reduce_pass got %h and=%b xor=%b want FF 1 0", result, red_and, red_xor);
    end
    in_valid = 1'b0;
    cycle();
  endtask
`endif

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = 8'h00; b = 8'h00; op = 3'd0;
    test_reset();
    test_all_ops();
    test_backpressure();
    test_zero();
    test_wrap();
    test_random();
    test_reset_mid();
`ifdef LOGIC_UNIT_REDUCE_EN
    test_reduce();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, registered bitwise logic unit: one N-bit operation per accepted transaction.
- Operation is selected by a 3-bit opcode (NOT/AND/NAND/OR/NOR/XOR/XNOR/PASS).
- Single pipeline stage with valid/ready handshake on both sides, full throughput under backpressure, and a wrapping count of accepted operations.
- Sits between an operand producer and any downstream consumer in the datapath; successor to the fixed 1-bit gate set.

Parameters:
- WIDTH, 8, operand and result width in bits (>=1).
- CNT_W, 16, width of the accepted-operation counter (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands/opcode valid.
- in_ready  output  1  unit can accept this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B (ignored by NOT and PASS).
- op  input  3  opcode: 0 NOT a, 1 AND, 2 NAND, 3 OR, 4 NOR, 5 XOR, 6 XNOR, 7 PASS a.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  registered bitwise result.
- zero  output  1  registered flag: result == 0.
- op_count  output  CNT_W  number of accepted input transactions, modulo 2^CNT_W.

Behaviour:
- Reset: synchronous, sampled on the rising edge of clk while rst_n=0. Clears out_valid=0, result=0, zero=0 and op_count=0. in_ready is combinational and reads 1 while out_valid=0.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational, no dependency on in_valid).
  - Accept occurs when in_valid && in_ready at the rising edge.
  - Output transfer occurs when out_valid && out_ready.
- On accept:
  - result <= f(op, a, b), applied bitwise across all WIDTH bits.
  - zero <= (f == 0).
  - out_valid <= 1.
  - op_count <= op_count + 1.
- Latency and throughput: latency 1 cycle from accept to out_valid. Throughput 1 op/cycle while out_ready=1.
- Output transfer with no accept in the same cycle: out_valid <= 0. result and zero hold their last values.
- Simultaneous output transfer and accept: the new result replaces the old one with no bubble; out_valid stays 1.
- Stall (out_valid=1, out_ready=0):
  - in_ready=0; inputs are ignored.
  - result, zero and out_valid hold stable.
  - in_valid may drop without effect.
- op_count wraps from 2^CNT_W-1 to 0 with no flag. It counts accepts only, never output transfers.
- Opcode is sampled only at accept. All 8 codes are legal; there is no illegal-opcode state.
- Reset mid-operation: a pending result is discarded (out_valid=0) in the cycle after reset is sampled, and op_count clears. The first accept is possible on the first edge where rst_n=1.
- While out_valid=0, result and zero are don't-care for consumers but must not be X after reset.

Optional Feature:
- Macro: LOGIC_UNIT_REDUCE_EN.
- With the macro defined: three extra outputs, each 1 bit, red_and, red_or and red_xor. They are the AND-, OR- and XOR-reduction of the computed result, registered in the same cycle as result. They reset to 0 and hold under stall, identical to result.
- Without the macro: these ports do not exist; all other behaviour is unchanged.

Test Plan:
- Reset then all opcodes, with WIDTH=8, a=8'hA5, b=8'h0F, out_ready=1, op 0..7 back-to-back. Required results in order: 5A, 05, FA, AF, 50, AA, 55, A5, one per cycle, each 1 cycle after its accept; op_count=8 at the end.
- Backpressure: accept AND of 8'hFF and 8'h3C, then hold out_ready=0 for 4 cycles while in_valid=1 with new data. Required: in_ready=0, result stays 3C and op_count stays 1. When out_ready=1, the new op is accepted in that same cycle.
- Zero flag: XOR of 8'h77 with 8'h77 gives result 00 with zero=1; then OR of 8'h00 with 8'h01 gives result 01 with zero=0.
- Counter wrap with CNT_W=4: 17 accepts from reset leave op_count=1. Output stalls do not advance the count.
- Reset mid-stream: with out_valid=1 and out_ready=0, drive rst_n=0 for 1 edge. Required next cycle: out_valid=0, result=0, op_count=0, in_ready=1.
- With LOGIC_UNIT_REDUCE_EN: NAND of 8'hF0 with 8'hF0 gives result 0F with red_and=0, red_or=1, red_xor=0. PASS of 8'hFF gives red_and=1, red_xor=0.
